// File: rtl/pix_pair_stream_tx_pkg.sv
// Shared definitions for the pixel-pair stream transmitter: FSM states, pair-packing
// field positions and width helpers.
package pix_pair_stream_tx_pkg;

  localparam int unsigned DEF_IMG_PIX_W = 8;
  localparam int unsigned PAIR_FIELDS   = 6;

  // Field index within a packed pair; index 5 occupies the MSBs.
  localparam int unsigned F_R0 = 5;
  localparam int unsigned F_G0 = 4;
  localparam int unsigned F_B0 = 3;
  localparam int unsigned F_R1 = 2;
  localparam int unsigned F_G1 = 1;
  localparam int unsigned F_B1 = 0;

  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VPRE,
    ST_LINE,
    ST_HGAP,
    ST_DRAIN,
    ST_DONE
  } tx_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pix_pair_stream_tx_timing.sv
// Frame timing for the pixel-pair source: FSM plus col/row/blank counters driving the
// memory read strobe/address, VSYNC, busy and the end-of-frame pulse.
module pix_stream_timing
  import pix_pair_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 64,
  parameter int unsigned HBLANK = 4,
  parameter int unsigned VBLANK = 8,
  parameter int unsigned ADDR_W = clog2_min1(WIDTH * HEIGHT / 2)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              VSYNC,
  output logic              busy,
  output logic              ctrl_done
);

  localparam int unsigned COL_W   = clog2_min1(WIDTH / 2);
  localparam int unsigned ROW_W   = clog2_min1(HEIGHT);
  localparam int unsigned BLANK_W = clog2_min1(max_u(HBLANK, VBLANK) + 1);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(WIDTH / 2 - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(HEIGHT - 1);
  localparam logic [BLANK_W-1:0] VB_LAST    = BLANK_W'(VBLANK - 1);
  localparam logic [BLANK_W-1:0] HB_LAST    = BLANK_W'(HBLANK - 1);
  localparam logic [BLANK_W-1:0] DRAIN_LAST = BLANK_W'(DRAIN_CYCLES - 1);

  tx_state_e           state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [BLANK_W-1:0]  blank_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rd_en_q;
  logic                vsync_q;
  logic                busy_q;
  logic                done_q;

  // Address advances on entry to each read except the first of the frame, so it
  // holds the last read address through gaps and after the frame.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      blank_q <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      vsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_VPRE;
            vsync_q <= 1'b1;
            busy_q  <= 1'b1;
            blank_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
          end
        end
        ST_VPRE: begin
          if (blank_q == VB_LAST) begin
            state_q <= ST_LINE;
            vsync_q <= 1'b0;
            rd_en_q <= 1'b1;
            blank_q <= '0;
          end else begin
            blank_q <= blank_q + BLANK_W'(1);
          end
        end
        ST_LINE: begin
          if (col_q == COL_LAST) begin
            rd_en_q <= 1'b0;
            col_q   <= '0;
            blank_q <= '0;
            state_q <= (row_q == ROW_LAST) ? ST_DRAIN : ST_HGAP;
          end else begin
            col_q  <= col_q + COL_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        ST_HGAP: begin
          if (blank_q == HB_LAST) begin
            state_q <= ST_LINE;
            rd_en_q <= 1'b1;
            row_q   <= row_q + ROW_W'(1);
            addr_q  <= addr_q + ADDR_W'(1);
            blank_q <= '0;
          end else begin
            blank_q <= blank_q + BLANK_W'(1);
          end
        end
        ST_DRAIN: begin
          if (blank_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            blank_q <= '0;
          end else begin
            blank_q <= blank_q + BLANK_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign VSYNC     = vsync_q;
  assign busy      = busy_q;
  assign ctrl_done = done_q;

endmodule

// File: rtl/pix_pair_stream_tx.sv
// Pixel-pair stream source: frame timing plus the two-stage read pipeline that turns
// frame-memory pairs into HSYNC-qualified DATA_* components.
module pix_pair_stream_tx
  import pix_pair_stream_tx_pkg::*;
#(
  parameter int unsigned IMG_PIX_W = DEF_IMG_PIX_W,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 64,
  parameter int unsigned HBLANK    = 4,
  parameter int unsigned VBLANK    = 8,
  parameter int unsigned ADDR_W    = clog2_min1(WIDTH * HEIGHT / 2)
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic                               start,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [PAIR_FIELDS*IMG_PIX_W-1:0]   mem_rdata,
  output logic                               VSYNC,
  output logic                               HSYNC,
  output logic [IMG_PIX_W-1:0]               DATA_R0,
  output logic [IMG_PIX_W-1:0]               DATA_G0,
  output logic [IMG_PIX_W-1:0]               DATA_B0,
  output logic [IMG_PIX_W-1:0]               DATA_R1,
  output logic [IMG_PIX_W-1:0]               DATA_G1,
  output logic [IMG_PIX_W-1:0]               DATA_B1,
  output logic                               busy,
  output logic                               ctrl_done
);

  logic                                       rd_en_d1_q;
  logic                                       hsync_q;
  logic [PAIR_FIELDS-1:0][IMG_PIX_W-1:0]      data_q;

  pix_stream_timing #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .HBLANK (HBLANK),
    .VBLANK (VBLANK),
    .ADDR_W (ADDR_W)
  ) u_timing (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .VSYNC     (VSYNC),
    .busy      (busy),
    .ctrl_done (ctrl_done)
  );

  // Stage 1 tracks the memory latency; stage 2 captures the returned pair.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_en_d1_q <= 1'b0;
      hsync_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      rd_en_d1_q <= mem_rd_en;
      hsync_q    <= rd_en_d1_q;
      if (rd_en_d1_q) begin
        data_q <= mem_rdata;
      end
    end
  end

  assign HSYNC   = hsync_q;
  assign DATA_R0 = data_q[F_R0];
  assign DATA_G0 = data_q[F_G0];
  assign DATA_B0 = data_q[F_B0];
  assign DATA_R1 = data_q[F_R1];
  assign DATA_G1 = data_q[F_G1];
  assign DATA_B1 = data_q[F_B1];

endmodule

// File: tb/tb_pix_pair_stream_tx.sv
// Directed bench for pix_pair_stream_tx with an 8x2 frame, HBLANK=2, VBLANK=3.
module tb_pix_pair_stream_tx;

  localparam int unsigned W      = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned NFRAME = 17;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic            start = 1'b0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [6*W-1:0]  mem_rdata = '0;
  logic            VSYNC, HSYNC, busy, ctrl_done;
  logic [W-1:0]    DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;

  int n_checks = 0;
  int n_pass   = 0;

  pix_pair_stream_tx #(
    .IMG_PIX_W (W),
    .WIDTH     (8),
    .HEIGHT    (2),
    .HBLANK    (2),
    .VBLANK    (3)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .VSYNC     (VSYNC),
    .HSYNC     (HSYNC),
    .DATA_R0   (DATA_R0),
    .DATA_G0   (DATA_G0),
    .DATA_B0   (DATA_B0),
    .DATA_R1   (DATA_R1),
    .DATA_G1   (DATA_G1),
    .DATA_B1   (DATA_B1),
    .busy      (busy),
    .ctrl_done (ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  // Frame memory: one-cycle read latency, pair = {6{addr}}.
  always @(posedge HCLK) begin
    if (mem_rd_en) mem_rdata <= {6{8'(mem_addr)}};
  end

  // Per-cycle expectations, k = 0 is the first cycle after start is sampled.
  // Flags are {VSYNC, mem_rd_en, HSYNC, ctrl_done, busy}.
  logic [4:0] exp_flags [NFRAME] = '{
    5'b10001, 5'b10001, 5'b10001,
    5'b01001, 5'b01001, 5'b01101, 5'b01101,
    5'b00101, 5'b00101,
    5'b01001, 5'b01001, 5'b01101, 5'b01101,
    5'b00101, 5'b00101,
    5'b00011, 5'b00000
  };
  int exp_addr [NFRAME] = '{0,0,0,0,1,2,3,3,3,4,5,6,7,7,7,7,7};
  // -1 means "still holding the value from before the frame".
  int exp_data [NFRAME] = '{-1,-1,-1,-1,-1,0,1,2,3,3,3,4,5,6,7,7,7};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [6*W-1:0] data_bus();
    return {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
  endfunction

  // Starts a frame and checks every cycle through the first idle cycle after DONE.
  // Returns positioned in that idle cycle (k = NFRAME-1) without advancing further.
  task automatic run_frame(input string name, input logic [7:0] d0, input bit repulse);
    logic [7:0] dv;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NFRAME; k++) begin
      check($sformatf("%s flags k=%0d", name, k),
            64'({VSYNC, mem_rd_en, HSYNC, ctrl_done, busy}), 64'(exp_flags[k]));
      check($sformatf("%s addr k=%0d", name, k), 64'(mem_addr), 64'(exp_addr[k]));
      dv = (exp_data[k] < 0) ? d0 : 8'(exp_data[k]);
      check($sformatf("%s data k=%0d", name, k), 64'(data_bus()), 64'({6{dv}}));
      start = (repulse && (k == 2 || k == 8 || k == 15)) ? 1'b1 : 1'b0;
      if (k < NFRAME - 1) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    logic saw_done;
    logic saw_busy;

    // Reset with start held: nothing may leave idle.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset outs c%0d", i),
            64'({VSYNC, HSYNC, mem_rd_en, ctrl_done, busy, mem_addr}), 64'd0);
      check($sformatf("reset data c%0d", i), 64'(data_bus()), 64'd0);
    end
    HRESET = 1'b0;
    start  = 1'b0;
    tick();
    check("post-reset busy", 64'(busy), 64'd0);
    check("post-reset vsync", 64'(VSYNC), 64'd0);

    run_frame("f1", 8'd0, 1'b0);
    tick();
    check("f1 idle busy", 64'(busy), 64'd0);
    check("f1 idle vsync", 64'(VSYNC), 64'd0);

    // Start re-pulsed during VPRE, HGAP and DONE, then a back-to-back frame.
    run_frame("f2", 8'd7, 1'b1);
    run_frame("f3", 8'd7, 1'b0);
    tick();
    check("f3 idle busy", 64'(busy), 64'd0);

    // Abort on the 3rd HSYNC of the second line.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 13; k++) tick();
    check("abort hsync before reset", 64'(HSYNC), 64'd1);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("abort outs", 64'({VSYNC, HSYNC, mem_rd_en, ctrl_done, busy, mem_addr}), 64'd0);
    check("abort data", 64'(data_bus()), 64'd0);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_done |= ctrl_done;
      saw_busy |= busy;
    end
    check("abort no done", 64'(saw_done), 64'd0);
    check("abort stays idle", 64'(saw_busy), 64'd0);

    run_frame("f4", 8'd0, 1'b0);
    tick();
    check("f4 idle busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
